id_stage: RTL
=============

Name: id_stage

Overview:
RV32I decode stage sitting directly upstream of the register file and downstream of fetch.
- Decodes the incoming instruction and drives the register file read addresses.
- Merges the read data with a writeback bypass.
- Generates the immediate and registers the result into the ID/EX pipeline register, using a valid/ready handshake.
- Detects load-use hazards against the instruction it currently holds, and honours branch flushes from EX.

Parameters:
XLEN, 32, datapath width; only 32 is supported.
BYPASS_EN, 1, 1 = forward wb_dat when wb_rd matches a source register in the same cycle; 0 = no bypass.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
if_valid  in  1  fetch presents an instruction
if_ready  out  1  decode accepts this cycle
if_pc  in  32  PC of the presented instruction
if_instr  in  32  presented instruction
r_reg0  out  5  register file read address 0 (rs1), combinational from if_instr
r_reg1  out  5  register file read address 1 (rs2), combinational from if_instr
r_dat0  in  32  register file read data 0
r_dat1  in  32  register file read data 1
wb_write  in  1  writeback commits this cycle
wb_rd  in  5  writeback destination
wb_dat  in  32  writeback data
flush  in  1  EX redirect; kill the held and incoming instructions
ex_ready  out/in: in  1  EX accepts the ID/EX register contents
id_valid  out  1  ID/EX register holds a live instruction
id_pc  out  32  registered PC
id_opcode  out  7  registered opcode
id_funct3  out  3  registered funct3
id_funct7b5  out  1  registered instr[30]
id_rd  out  5  registered rd (forced to 0 for S and B types)
id_rs1  out  5  registered rs1
id_rs2  out  5  registered rs2
id_rs1_val  out  32  registered rs1 operand
id_rs2_val  out  32  registered rs2 operand
id_imm  out  32  registered sign-extended immediate
id_illegal  out  1  registered; opcode is not an RV32I base opcode

Behaviour:
- Reset (rst_n low, asynchronous): every registered output is 0, including id_valid.
- if_ready is combinational:
  - if flush: if_ready = 1.
  - otherwise: if_ready = (!id_valid | ex_ready) & !hazard.
- Transfer from fetch: occurs when if_valid & if_ready & !flush. On the next edge the ID/EX register loads the decoded fields and id_valid is set to 1. Latency is 1 cycle.
- Drain: when id_valid & ex_ready and there is no new transfer, id_valid goes to 0 on the next edge.
- Hold: when id_valid & !ex_ready, all id_* outputs stay bit-stable.
- Flush: id_valid goes to 0 on the next edge. A coincident if_valid instruction is consumed and discarded. Flush has priority over hazard and transfer.
- Hazard (load-use): id_valid & id_opcode==LOAD & id_rd!=0 & ((uses_rs1 & rs1==id_rd) | (uses_rs2 & rs2==id_rd)).
  - uses_rs1 opcodes: JALR, BRANCH, LOAD, STORE, OP-IMM, OP.
  - uses_rs2 opcodes: BRANCH, STORE, OP.
  - While a hazard is active, ex_ready lets the load drain and id_valid becomes 0 (bubble). The dependent instruction is accepted the following cycle.
- Operand select: rs==0 gives 0. Otherwise, if BYPASS_EN & wb_write & wb_rd==rs, the operand is wb_dat. Otherwise it is r_dat.
- Immediate by opcode:
  - I-type (LOAD, OP-IMM, JALR): instr[31:20] sign-extended.
  - S-type: {instr[31:25], instr[11:7]} sign-extended.
  - B-type: {instr[31], instr[7], instr[30:25], instr[11:8], 0} sign-extended.
  - U-type (LUI, AUIPC): {instr[31:12], 12'b0}.
  - J-type: {instr[31], instr[19:12], instr[20], instr[30:21], 0} sign-extended.
  - All other opcodes: 0.
- Illegal opcode: the instruction still flows with id_illegal=1, id_rd=0 and id_imm=0.
- Reset mid-operation: the ID/EX contents are lost and no transfer occurs while rst_n is low.

Decomposition:
- Package riscv_pkg holds:
  - opcode localparams: LOAD 0000011, OP_IMM 0010011, AUIPC 0010111, STORE 0100011, OP 0110011, LUI 0110111, BRANCH 1100011, JALR 1100111, JAL 1101111, SYSTEM 1110011, MISC_MEM 0001111.
  - imm_type_t enum: I, S, B, U, J, NONE.
- One combinational sub-module, imm_gen, takes (instr) and produces imm. It is reused later by the branch unit.

Test Plan:
- Reset, then addi x1,x0,5 (0x00500093) with ex_ready=1 -> after 1 cycle: id_valid=1, id_opcode=0x13, id_rd=1, id_rs1=0, id_rs1_val=0, id_imm=5.
- lw x2,0(x1) (0x0000A103) followed by add x3,x2,x1 (0x001101B3), back-to-back -> if_ready=0 for exactly 1 cycle and a 1-cycle id_valid=0 bubble; add is then presented with id_rs1=2, id_rs2=1.
- add x3,x2,x1 issued with wb_write=1, wb_rd=2, wb_dat=0xDEADBEEF, r_dat0=0x11 -> id_rs1_val=0xDEADBEEF. Same stimulus with wb_rd=0 -> id_rs1_val=0x11.
- beq x1,x2,-4 (0xFE208EE3) -> id_imm=0xFFFFFFFC, id_rd=0. Then hold ex_ready=0 for 3 cycles -> all id_* outputs unchanged and if_ready=0.
- Instruction held with ex_ready=0, then flush=1 together with if_valid=1 -> if_ready=1, and id_valid=0 next cycle. Drive rst_n low mid-hold -> all outputs are 0 immediately, before any clock edge.
- Opcode 0x7F -> id_illegal=1, id_imm=0.

Source files
------------

// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : riscv_pkg
//  Purpose  : RV32I base opcodes, immediate formats and opcode classifiers
//             shared by the decode stage and the immediate generator.
//  Revision : 1.0 - initial release
// ============================================================================
package riscv_pkg;

   localparam logic [6:0] LOAD     = 7'b0000011;
   localparam logic [6:0] OP_IMM   = 7'b0010011;
   localparam logic [6:0] AUIPC    = 7'b0010111;
   localparam logic [6:0] STORE    = 7'b0100011;
   localparam logic [6:0] OP       = 7'b0110011;
   localparam logic [6:0] LUI      = 7'b0110111;
   localparam logic [6:0] BRANCH   = 7'b1100011;
   localparam logic [6:0] JALR     = 7'b1100111;
   localparam logic [6:0] JAL      = 7'b1101111;
   localparam logic [6:0] SYSTEM   = 7'b1110011;
   localparam logic [6:0] MISC_MEM = 7'b0001111;

   typedef enum logic [2:0] {
      IMM_I    = 3'd0,
      IMM_S    = 3'd1,
      IMM_B    = 3'd2,
      IMM_U    = 3'd3,
      IMM_J    = 3'd4,
      IMM_NONE = 3'd5
   } imm_type_t;

   // Immediate format selected by the major opcode.
   function automatic imm_type_t imm_type_of(input logic [6:0] opc);
      case (opc)
         LOAD, OP_IMM, JALR: imm_type_of = IMM_I;
         STORE:              imm_type_of = IMM_S;
         BRANCH:             imm_type_of = IMM_B;
         LUI, AUIPC:         imm_type_of = IMM_U;
         JAL:                imm_type_of = IMM_J;
         default:            imm_type_of = IMM_NONE;
      endcase
   endfunction

   // True for any of the eleven RV32I base opcodes.
   function automatic logic is_legal(input logic [6:0] opc);
      case (opc)
         LOAD, OP_IMM, AUIPC, STORE, OP, LUI,
         BRANCH, JALR, JAL, SYSTEM, MISC_MEM: is_legal = 1'b1;
         default:                             is_legal = 1'b0;
      endcase
   endfunction

   // Opcodes that actually read rs1.
   function automatic logic uses_rs1(input logic [6:0] opc);
      case (opc)
         JALR, BRANCH, LOAD, STORE, OP_IMM, OP: uses_rs1 = 1'b1;
         default:                               uses_rs1 = 1'b0;
      endcase
   endfunction

   // Opcodes that actually read rs2.
   function automatic logic uses_rs2(input logic [6:0] opc);
      case (opc)
         BRANCH, STORE, OP: uses_rs2 = 1'b1;
         default:           uses_rs2 = 1'b0;
      endcase
   endfunction

endpackage
`default_nettype wire

// File: rtl/imm_gen.sv
`default_nettype none
// ============================================================================
//  Module   : imm_gen
//  Purpose  : Combinational RV32I immediate extraction and sign extension.
//             Opcodes without an immediate format yield zero.
//  Revision : 1.0 - initial release
// ============================================================================
module imm_gen
   import riscv_pkg::*;
(
   input  logic [31:0] instr,
   output logic [31:0] imm
);

   // Assemble the immediate according to the opcode's encoding format.
   always_comb begin
      imm = '0;
      case (imm_type_of(instr[6:0]))
         IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
         IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
         IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
         IMM_U:   imm = {instr[31:12], 12'b0};
         IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
         default: imm = '0;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/id_stage.sv
`default_nettype none
// ============================================================================
//  Module   : id_stage
//  Purpose  : RV32I decode stage. Drives register file read addresses,
//             merges writeback bypass, builds the immediate and registers the
//             decoded instruction into the ID/EX register with valid/ready
//             flow control, load-use stall and EX flush.
//  Revision : 1.0 - initial release
// ============================================================================
module id_stage
   import riscv_pkg::*;
#(
   parameter int XLEN      = 32,
   parameter bit BYPASS_EN = 1'b1
)(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            if_valid,
   output logic            if_ready,
   input  logic [XLEN-1:0] if_pc,
   input  logic [31:0]     if_instr,
   output logic [4:0]      r_reg0,
   output logic [4:0]      r_reg1,
   input  logic [XLEN-1:0] r_dat0,
   input  logic [XLEN-1:0] r_dat1,
   input  logic            wb_write,
   input  logic [4:0]      wb_rd,
   input  logic [XLEN-1:0] wb_dat,
   input  logic            flush,
   input  logic            ex_ready,
   output logic            id_valid,
   output logic [XLEN-1:0] id_pc,
   output logic [6:0]      id_opcode,
   output logic [2:0]      id_funct3,
   output logic            id_funct7b5,
   output logic [4:0]      id_rd,
   output logic [4:0]      id_rs1,
   output logic [4:0]      id_rs2,
   output logic [XLEN-1:0] id_rs1_val,
   output logic [XLEN-1:0] id_rs2_val,
   output logic [XLEN-1:0] id_imm,
   output logic            id_illegal
);

   logic [6:0]      opc;
   logic [4:0]      rs1;
   logic [4:0]      rs2;
   logic            legal;
   logic [4:0]      rd_dec;
   logic [31:0]     imm;
   logic            byp0;
   logic            byp1;
   logic [XLEN-1:0] rs1_val;
   logic [XLEN-1:0] rs2_val;
   logic            hazard;
   logic            take;

   assign opc    = if_instr[6:0];
   assign rs1    = if_instr[19:15];
   assign rs2    = if_instr[24:20];
   assign r_reg0 = rs1;
   assign r_reg1 = rs2;
   assign legal  = is_legal(opc);

   // S/B formats have no destination; illegal instructions must not write back.
   assign rd_dec = (!legal || opc == STORE || opc == BRANCH) ? 5'd0 : if_instr[11:7];

   imm_gen u_imm_gen (
      .instr (if_instr),
      .imm   (imm)
   );

   generate
      if (BYPASS_EN) begin : g_bypass
         assign byp0 = wb_write && (wb_rd == rs1);
         assign byp1 = wb_write && (wb_rd == rs2);
      end else begin : g_no_bypass
         assign byp0 = 1'b0;
         assign byp1 = 1'b0;
      end
   endgenerate

   // x0 reads as zero even if writeback targets it.
   assign rs1_val = (rs1 == 5'd0) ? '0 : (byp0 ? wb_dat : r_dat0);
   assign rs2_val = (rs2 == 5'd0) ? '0 : (byp1 ? wb_dat : r_dat1);

   // Load-use: the held load's result is not yet available to a dependent reader.
   assign hazard = id_valid && (id_opcode == LOAD) && (id_rd != 5'd0) &&
                   ((uses_rs1(opc) && rs1 == id_rd) || (uses_rs2(opc) && rs2 == id_rd));

   // A flush always drains fetch so the wrong-path instruction is discarded.
   assign if_ready = flush ? 1'b1 : ((!id_valid || ex_ready) && !hazard);
   assign take     = if_valid && if_ready && !flush;

   // ID/EX pipeline register: flush beats transfer, transfer beats drain.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         id_valid    <= 1'b0;
         id_pc       <= '0;
         id_opcode   <= '0;
         id_funct3   <= '0;
         id_funct7b5 <= 1'b0;
         id_rd       <= '0;
         id_rs1      <= '0;
         id_rs2      <= '0;
         id_rs1_val  <= '0;
         id_rs2_val  <= '0;
         id_imm      <= '0;
         id_illegal  <= 1'b0;
      end else if (flush) begin
         id_valid <= 1'b0;
      end else if (take) begin
         id_valid    <= 1'b1;
         id_pc       <= if_pc;
         id_opcode   <= opc;
         id_funct3   <= if_instr[14:12];
         id_funct7b5 <= if_instr[30];
         id_rd       <= rd_dec;
         id_rs1      <= rs1;
         id_rs2      <= rs2;
         id_rs1_val  <= rs1_val;
         id_rs2_val  <= rs2_val;
         id_imm      <= imm;
         id_illegal  <= !legal;
      end else if (ex_ready) begin
         id_valid <= 1'b0;
      end
   end

endmodule
`default_nettype wire
